// File: rtl/mul16_seq_mult_if.sv
// Operand/result bundle of the sequential 16-bit multiplier.
// Ports (master = requester, slave = multiplier):
//   start   : operation request and done/start handshake
//   data_in : operand bus, A then B
//   y       : product register
//   done    : result valid
//   ovf     : sticky overflow, only with MUL16_OVF_EN defined
interface mul16_seq_mult_if;

    logic        start;
    logic [15:0] data_in;
    logic [15:0] y;
    logic        done;
`ifdef MUL16_OVF_EN
    logic        ovf;
`endif

`ifdef MUL16_OVF_EN
    modport master (
        output start,
        output data_in,
        input  y,
        input  done,
        input  ovf
    );

    modport slave (
        input  start,
        input  data_in,
        output y,
        output done,
        output ovf
    );
`else
    modport master (
        output start,
        output data_in,
        input  y,
        input  done
    );

    modport slave (
        input  start,
        input  data_in,
        output y,
        output done
    );
`endif

endinterface

// File: rtl/mul16_seq_mult.sv
// Sequential 16-bit unsigned multiplier using repeated addition.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mul16_seq_mult_if.slave (start, data_in, y, done[, ovf])
// Optional macro MUL16_OVF_EN adds a sticky overflow flag (bus.ovf).
module mul16_seq_mult (
    input  logic                  clk,
    input  logic                  rst,
    mul16_seq_mult_if.slave       bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        MUL,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic [15:0] sum;
    logic        eqz;

    logic ld_a;
    logic ld_b;
    logic clr_p;
    logic ld_p;
    logic dec_b;

    assign eqz = (b == 16'd0);

    // ---------------- control FSM ----------------

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        clr_p    = 1'b0;
        ld_p     = 1'b0;
        dec_b    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = LOAD_A;
                end
            end
            LOAD_A: begin
                ld_a     = 1'b1;
                state_nx = LOAD_B;
            end
            LOAD_B: begin
                ld_b     = 1'b1;
                clr_p    = 1'b1;
                state_nx = MUL;
            end
            MUL: begin
                // B counts the remaining additions of A into P
                if (eqz) begin
                    state_nx = DONE;
                end else begin
                    ld_p  = 1'b1;
                    dec_b = 1'b1;
                end
            end
            DONE: begin
                // start must drop before a new request is accepted
                if (!bus.start) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------

`ifdef MUL16_OVF_EN
    logic [16:0] sum_full;
    logic        ovf;

    assign sum_full = {1'b0, p} + {1'b0, a};
    assign sum      = sum_full[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clr_p) begin
            ovf <= 1'b0;
        end else if (ld_p && sum_full[16]) begin
            ovf <= 1'b1;
        end
    end

    assign bus.ovf = ovf;
`else
    assign sum = p + a;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            a <= 16'd0;
        end else if (ld_a) begin
            a <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b <= 16'd0;
        end else if (ld_b) begin
            b <= bus.data_in;
        end else if (dec_b) begin
            b <= b - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p <= 16'd0;
        end else if (clr_p) begin
            p <= 16'd0;
        end else if (ld_p) begin
            p <= sum;
        end
    end

    assign bus.y    = p;
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_mul16_seq_mult.sv
// Scoreboard bench for mul16_seq_mult: directed operands, expected
// products/latencies queued at issue and checked when done rises.
module tb_mul16_seq_mult;

    logic clk;
    logic rst;

    mul16_seq_mult_if bus();

    mul16_seq_mult dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] y;
        logic        ovf;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic        ovf;
        int          hold;
        string       name;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic done_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // monitor: compare on each rising edge of done
    always @(negedge clk) begin
        if (!rst && bus.done && !done_q) begin
            if (sb.size() == 0) begin
                chk("unexpected done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, " y"}, 32'(bus.y), 32'(e.y));
                chk({e.name, " latency"}, 32'(cyc - e.t0), 32'(e.lat));
`ifdef MUL16_OVF_EN
                chk({e.name, " ovf"}, 32'(bus.ovf), 32'(e.ovf));
`endif
            end
        end
        done_q <= bus.done;
    end

    task automatic run_op(input vec_t v);
        int n;
        exp_t e;
        @(negedge clk);
        e.y    = v.y;
        e.ovf  = v.ovf;
        e.lat  = int'(v.b) + 4;
        e.t0   = cyc;
        e.name = v.name;
        sb.push_back(e);
        bus.start   = 1'b1;
        bus.data_in = 16'($urandom);
        @(negedge clk);
        bus.data_in = v.a;
        @(negedge clk);
        bus.data_in = v.b;
        n = 0;
        while (!bus.done && n < int'(v.b) + 10) begin
            @(negedge clk);
            bus.data_in = 16'($urandom);
            n++;
        end
        chk({v.name, " done reached"}, 32'(bus.done), 32'd1);
        repeat (v.hold) begin
            @(negedge clk);
            bus.data_in = 16'($urandom);
            chk({v.name, " done held"}, 32'(bus.done), 32'd1);
            chk({v.name, " y held"}, 32'(bus.y), 32'(v.y));
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk({v.name, " done drop"}, 32'(bus.done), 32'd0);
    endtask

    vec_t vecs1[7];
    vec_t vecs2[2];

    initial begin
        vecs1[0] = '{16'd17,    16'd5,   16'd85,    1'b0, 3, "17x5"};
        vecs1[1] = '{16'd1234,  16'd0,   16'd0,     1'b0, 1, "1234x0"};
        vecs1[2] = '{16'd0,     16'd3,   16'd0,     1'b0, 1, "0x3"};
        vecs1[3] = '{16'd300,   16'd300, 16'd24464, 1'b1, 1, "300x300"};
        vecs1[4] = '{16'd255,   16'd257, 16'd65535, 1'b0, 1, "255x257"};
        vecs1[5] = '{16'd65535, 16'd2,   16'd65534, 1'b1, 1, "ffffx2"};
        vecs1[6] = '{16'd7,     16'd9,   16'd63,    1'b0, 2, "7x9"};
        vecs2[0] = '{16'd3,     16'd4,   16'd12,    1'b0, 1, "3x4"};
        vecs2[1] = '{16'd6,     16'd7,   16'd42,    1'b0, 4, "6x7"};

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset y", 32'(bus.y), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
`ifdef MUL16_OVF_EN
        chk("reset ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;

        foreach (vecs1[i]) run_op(vecs1[i]);

        // abort a long multiply part-way through
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 16'd100;
        @(negedge clk);
        bus.data_in = 16'd100;
        @(negedge clk);
        bus.data_in = 16'd50;
        repeat (10) @(negedge clk);
        chk("mid-mul busy", 32'(bus.done), 32'd0);
        chk("mid-mul partial y", 32'(bus.y != 16'd0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort y", 32'(bus.y), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
`ifdef MUL16_OVF_EN
        chk("abort ovf", 32'(bus.ovf), 32'd0);
`endif
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("abort idle", 32'(bus.done), 32'd0);
        end

        foreach (vecs2[i]) run_op(vecs2[i]);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
